// File: rtl/mem_arb_pkg.sv
// Shared types for mem_arbiter: FSM states, bus owner encoding and the default busy timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam int MEM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/arb_watchdog.sv
// Busy-cycle counter for mem_arbiter: cleared on issue, counts each busy cycle.
// expired is combinational in the cycle the count reaches TIMEOUT-1 while enabled.
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // TIMEOUT tops out at 255, so the count never passes 254 before the FSM leaves BUSY.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expired = enable && (r_count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// IF/LS arbiter onto one memory port, one outstanding txn; grant same cycle, completion mirrors i_mem_rvalid.
// Requesters hold req until gnt; one bubble after each completion; MEM_ARB_RR_EN makes contention round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_ls_req,
  input  logic        i_ls_we,
  input  logic [31:0] i_ls_addr,
  input  logic [31:0] i_ls_wdata,
  input  logic [3:0]  i_ls_bmask,
  output logic        o_ls_gnt,
  output logic        o_ls_rvalid,
  output logic [31:0] o_ls_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_err
);

  state_t r_state;
  logic   w_idle;
  logic   w_issue;
  logic   w_pick_ls;
  logic   w_gnt_if;
  logic   w_gnt_ls;
  logic   w_busy;
  logic   w_expired;

  // Gating with i_reset keeps grants low while reset is held, even with requests pending.
  assign w_idle  = i_reset && (r_state == IDLE);
  assign w_issue = w_idle && (i_if_req || i_ls_req);

`ifdef MEM_ARB_RR_EN
  owner_t r_last_own;

  assign w_pick_ls = i_ls_req && (!i_if_req || (r_last_own == OWN_IF));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_last_own <= OWN_IF;
    end else if (w_issue) begin
      r_last_own <= w_pick_ls ? OWN_LS : OWN_IF;
    end
  end
`else
  assign w_pick_ls = i_ls_req;
`endif

  assign w_gnt_ls = w_issue && w_pick_ls;
  assign w_gnt_if = w_issue && !w_pick_ls;
  assign w_busy   = (r_state == BUSY_IF) || (r_state == BUSY_LS);

  arb_watchdog #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_watchdog (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   (w_issue),
    .enable  (w_busy),
    .expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_ls) begin
            r_state <= BUSY_LS;
          end else if (w_gnt_if) begin
            r_state <= BUSY_IF;
          end
        end
        BUSY_IF, BUSY_LS: begin
          if (i_mem_rvalid || w_expired) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_if_gnt    = w_gnt_if;
  assign o_ls_gnt    = w_gnt_ls;
  assign o_mem_req   = w_issue;
  assign o_mem_we    = w_gnt_ls && i_ls_we;
  assign o_mem_addr  = w_gnt_ls ? i_ls_addr  : (w_gnt_if ? i_if_addr : 32'd0);
  assign o_mem_wdata = w_gnt_ls ? i_ls_wdata : 32'd0;
  assign o_mem_bmask = w_gnt_ls ? i_ls_bmask : (w_gnt_if ? 4'hF : 4'h0);

  // Completion outruns the watchdog when both land in the same cycle.
  assign o_if_rvalid = (r_state == BUSY_IF) && i_mem_rvalid;
  assign o_ls_rvalid = (r_state == BUSY_LS) && i_mem_rvalid;
  assign o_if_rdata  = o_if_rvalid ? i_mem_rdata : 32'd0;
  assign o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : 32'd0;
  assign o_err       = w_expired && !i_mem_rvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: completions queued at issue, popped when the DUT reports rvalid.
module tb_mem_arbiter;

  localparam int TO = 4;

  logic        i_clk;
  logic        i_reset;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt;
  logic        o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_ls_req;
  logic        i_ls_we;
  logic [31:0] i_ls_addr;
  logic [31:0] i_ls_wdata;
  logic [3:0]  i_ls_bmask;
  logic        o_ls_gnt;
  logic        o_ls_rvalid;
  logic [31:0] o_ls_rdata;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_err;

  mem_arbiter #(
    .MEM_TIMEOUT (TO)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_if_req     (i_if_req),
    .i_if_addr    (i_if_addr),
    .o_if_gnt     (o_if_gnt),
    .o_if_rvalid  (o_if_rvalid),
    .o_if_rdata   (o_if_rdata),
    .i_ls_req     (i_ls_req),
    .i_ls_we      (i_ls_we),
    .i_ls_addr    (i_ls_addr),
    .i_ls_wdata   (i_ls_wdata),
    .i_ls_bmask   (i_ls_bmask),
    .o_ls_gnt     (o_ls_gnt),
    .o_ls_rvalid  (o_ls_rvalid),
    .o_ls_rdata   (o_ls_rdata),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_bmask  (o_mem_bmask),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        ls;
    logic [31:0] data;
  } cpl_t;

  cpl_t cpl_q[$];
  int   n_total    = 0;
  int   n_bad      = 0;
  int   n_cpl_exp  = 0;
  int   n_err_exp  = 0;
  int   n_rv_seen  = 0;
  int   n_err_seen = 0;
  int   n_leak     = 0;
  bit   m_last_ls  = 1'b0;
  bit   hold_if    = 1'b0;
  bit   hold_ls    = 1'b0;
  bit   first_ls;
  logic any_out;

  assign any_out = |{o_if_gnt, o_if_rvalid, o_if_rdata, o_ls_gnt, o_ls_rvalid, o_ls_rdata,
                     o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_bmask, o_err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference arbitration: LS-first, or alternate-on-contention when round-robin is built in.
  function automatic bit pick_ls(input bit ifr, input bit lsr);
`ifdef MEM_ARB_RR_EN
    return lsr && (!ifr || !m_last_ls);
`else
    return lsr && (ifr || !ifr);
`endif
  endfunction

  always @(negedge i_clk) begin
    if (o_if_rvalid || o_ls_rvalid) n_rv_seen++;
    if (o_err) n_err_seen++;
    if ((!o_if_rvalid && o_if_rdata != 32'd0) || (!o_ls_rvalid && o_ls_rdata != 32'd0)) n_leak++;
  end

  // Waits for the issue, checks the memory-side request, then answers after lat cycles.
  task automatic serve(input bit exp_ls, input logic [31:0] rd, input int lat);
    int   w;
    cpl_t e;
    bit   any_rv;
    w = 0;
    @(negedge i_clk);
    while (!o_mem_req && w < 40) begin
      @(negedge i_clk);
      w++;
    end
    chk("issue", 32'(o_mem_req), 32'd1);
    if (!o_mem_req) return;
    chk("issue_gap", 32'(w), 32'd0);
    chk("ls_gnt", 32'(o_ls_gnt), 32'(exp_ls));
    chk("if_gnt", 32'(o_if_gnt), 32'(!exp_ls));
    chk("mem_addr", o_mem_addr, exp_ls ? i_ls_addr : i_if_addr);
    chk("mem_we", 32'(o_mem_we), exp_ls ? 32'(i_ls_we) : 32'd0);
    chk("mem_bmask", 32'(o_mem_bmask), exp_ls ? 32'(i_ls_bmask) : 32'hF);
    if (exp_ls) chk("mem_wdata", o_mem_wdata, i_ls_wdata);
    m_last_ls = exp_ls;
    if (lat <= TO) begin
      e.ls   = exp_ls;
      e.data = rd;
      cpl_q.push_back(e);
      n_cpl_exp++;
    end else begin
      n_err_exp++;
    end
    for (int k = 1; k <= lat; k++) begin
      @(posedge i_clk); #1;
      if (k == 1) begin
        if (exp_ls && !hold_ls) i_ls_req = 1'b0;
        if (!exp_ls && !hold_if) i_if_req = 1'b0;
      end
      if (k == lat) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rd;
      end
      @(negedge i_clk);
      chk("bubble_req", 32'(o_mem_req), 32'd0);
      chk("err", 32'(o_err), 32'(k == TO && lat != TO));
      if (k == lat) begin
        any_rv = o_if_rvalid || o_ls_rvalid;
        chk("rvalid", 32'(any_rv), 32'(lat <= TO));
        if (any_rv) begin
          if (cpl_q.size() == 0) begin
            chk("cpl_underflow", 32'(any_rv), 32'd0);
          end else begin
            e = cpl_q.pop_front();
            chk("rv_ls", 32'(o_ls_rvalid), 32'(e.ls));
            chk("rv_if", 32'(o_if_rvalid), 32'(!e.ls));
            chk("rdata", e.ls ? o_ls_rdata : o_if_rdata, e.data);
          end
        end
      end
    end
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1, "bench stopped");
  end

  initial begin
    i_reset      = 1'b0;
    i_if_req     = 1'b1;
    i_ls_req     = 1'b1;
    i_if_addr    = 32'h4;
    i_ls_we      = 1'b1;
    i_ls_addr    = 32'h8;
    i_ls_wdata   = 32'h55;
    i_ls_bmask   = 4'hF;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'd0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_outs", 32'(any_out), 32'd0);
    @(posedge i_clk); #1;
    i_if_req = 1'b0;
    i_ls_req = 1'b0;
    i_ls_we  = 1'b0;
    i_reset  = 1'b1;
    m_last_ls = 1'b0;
    @(negedge i_clk);
    chk("idle_outs", 32'(any_out), 32'd0);
    @(posedge i_clk); #1;

    // Fetch only, completion two cycles after grant.
    i_if_req  = 1'b1;
    i_if_addr = 32'h100;
    serve(1'b0, 32'h00500093, 2);

    // Both request together; loser must issue in the first idle cycle.
    i_if_addr  = 32'h104;
    i_ls_addr  = 32'h2000;
    i_ls_we    = 1'b0;
    i_ls_wdata = 32'h12345678;
    i_ls_bmask = 4'hF;
    i_if_req   = 1'b1;
    i_ls_req   = 1'b1;
    first_ls   = pick_ls(1'b1, 1'b1);
    serve(first_ls, $urandom, 3);
    serve(!first_ls, $urandom, 1);

    // Partial store.
    i_ls_req   = 1'b1;
    i_ls_we    = 1'b1;
    i_ls_bmask = 4'b0011;
    i_ls_addr  = 32'h7000;
    i_ls_wdata = 32'hDEADBEEF;
    serve(1'b1, $urandom, 2);
    i_ls_we    = 1'b0;
    i_ls_bmask = 4'hF;

    // Both held high across four transactions.
    hold_if   = 1'b1;
    hold_ls   = 1'b1;
    i_if_addr = 32'h80;
    i_ls_addr = 32'h40;
    i_if_req  = 1'b1;
    i_ls_req  = 1'b1;
    for (int t = 0; t < 4; t++) begin
      serve(pick_ls(1'b1, 1'b1), $urandom, 1 + (t % 2));
    end
    i_if_req = 1'b0;
    i_ls_req = 1'b0;
    hold_if  = 1'b0;
    hold_ls  = 1'b0;

    // Timeout, with rvalid arriving after the arbiter has given up.
    i_if_req  = 1'b1;
    i_if_addr = 32'h500;
    serve(1'b0, $urandom, TO + 2);

    // Completion in the same cycle the watchdog expires.
    i_ls_req  = 1'b1;
    i_ls_addr = 32'h600;
    serve(1'b1, $urandom, TO);

    // Reset in the middle of a load, then a stray rvalid.
    i_ls_req  = 1'b1;
    i_ls_addr = 32'h3000;
    @(negedge i_clk);
    chk("rst_issue", 32'(o_ls_gnt), 32'd1);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("rst_busy_outs", 32'(any_out), 32'd0);
    @(posedge i_clk); #1;
    i_reset      = 1'b1;
    i_ls_req     = 1'b0;
    m_last_ls    = 1'b0;
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hCAFEF00D;
    @(negedge i_clk);
    chk("rst_stray_rv", 32'(any_out), 32'd0);
    @(posedge i_clk); #1;
    i_mem_rvalid = 1'b0;
    i_mem_rdata  = 32'd0;
    i_if_req     = 1'b1;
    i_if_addr    = 32'h900;
    serve(1'b0, $urandom, 1);

    chk("rv_count", 32'(n_rv_seen), 32'(n_cpl_exp));
    chk("err_count", 32'(n_err_seen), 32'(n_err_exp));
    chk("rdata_leak", 32'(n_leak), 32'd0);
    chk("cpl_left", 32'(cpl_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
